// File: rtl/alu_sequencer.sv
// Control FSM feeding the ALU datapath: one reg-to-reg instruction per handshake, 5 cycles each.
// Optional SEQ_HOLD_EN adds a `hold` input that freezes the sequence and masks all bus strobes.
module alu_sequencer #(
  parameter int IDX_W    = 2,
  parameter int NUM_REGS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef SEQ_HOLD_EN
  input  logic                   hold,
`endif
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [3+3*IDX_W-1:0]   instr,
  output logic [2:0]             opControl,
  output logic                   ALUin0,
  output logic                   ALUin1,
  output logic                   ALUOutLatch,
  output logic                   ALUOutEn,
  output logic [NUM_REGS-1:0]    reg_out_en,
  output logic [NUM_REGS-1:0]    reg_in_en,
  output logic                   busy,
  output logic                   done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;

  logic [2:0]             state;
  logic [3+3*IDX_W-1:0]   ir;
  logic                   done_q;
  logic                   hold_i;
  logic                   active;

  logic [2:0]             op;
  logic [IDX_W-1:0]       src_a;
  logic [IDX_W-1:0]       src_b;
  logic [IDX_W-1:0]       dst;

`ifdef SEQ_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  assign active = !hold_i;

  assign op    = ir[3+3*IDX_W-1 -: 3];
  assign src_a = ir[3*IDX_W-1 -: IDX_W];
  assign src_b = ir[2*IDX_W-1 -: IDX_W];
  assign dst   = ir[IDX_W-1:0];

  // done_q freezes with the state so a held retire still pulses once hold drops
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ir     <= '0;
      done_q <= 1'b0;
    end else if (active) begin
      done_q <= (state == WRITE);
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= LOAD_A;
          end
        end
        LOAD_A:  state <= LOAD_B;
        LOAD_B:  state <= EXEC;
        EXEC:    state <= WRITE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    instr_ready = (state == IDLE) && active;
    busy        = (state != IDLE);
    opControl   = (state == IDLE) ? 3'b000 : op;
    ALUin0      = active && (state == LOAD_A);
    ALUin1      = active && (state == LOAD_B);
    ALUOutLatch = active && (state == EXEC);
    ALUOutEn    = active && (state == WRITE);
    done        = active && done_q;
    reg_out_en  = '0;
    reg_in_en   = '0;
    // indices >= NUM_REGS match no bit, leaving the vector all zero
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out_en[i] = active && (((state == LOAD_A) && (src_a == IDX_W'(i))) ||
                                 ((state == LOAD_B) && (src_b == IDX_W'(i))));
      reg_in_en[i]  = active && (state == WRITE) && (dst == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a per-cycle bus-exclusivity monitor and retire accounting.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr;
  logic [2:0] opControl;
  logic       ALUin0, ALUin1, ALUOutLatch, ALUOutEn;
  logic [3:0] reg_out_en, reg_in_en;
  logic       busy, done;
`ifdef SEQ_HOLD_EN
  logic       hold = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_hs     = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.IDX_W(2), .NUM_REGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SEQ_HOLD_EN
    .hold        (hold),
`endif
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opControl   (opControl),
    .ALUin0      (ALUin0),
    .ALUin1      (ALUin1),
    .ALUOutLatch (ALUOutLatch),
    .ALUOutEn    (ALUOutEn),
    .reg_out_en  (reg_out_en),
    .reg_in_en   (reg_in_en),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v;
  endfunction

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] d);
    return {op, a, b, d};
  endfunction

  // Handshakes counted at the edge; outputs checked mid-cycle.
  always @(posedge clk) if (!rst && instr_valid && instr_ready) n_hs++;

  always @(negedge clk) begin
    if (!rst) begin
      if (done) n_done++;
      check("bus_excl", 32'($countones(reg_out_en) + int'(ALUOutEn) <= 1), 32'd1);
      check("in_onehot", 32'($countones(reg_in_en) <= 1), 32'd1);
    end
  end

  logic [8:0] bb [3];
  int hs0, dn0, cyc;

  initial begin
    rst = 1'b1;
    instr_valid = 1'b1;
    instr = mk(3'b101, 2'd1, 2'd2, 2'd3);
    @(negedge clk);
    step();
    step();
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_strobes", {ALUin0, ALUin1, ALUOutLatch, ALUOutEn, done}, 0);
    check("rst_en", {reg_out_en, reg_in_en}, 0);
    check("rst_op", opControl, 0);
    rst = 1'b0;
    instr_valid = 1'b0;
    step();
    check("rst_noaccept", busy, 0);

    // single op
    instr_valid = 1'b1;
    instr = mk(3'b010, 2'd1, 2'd2, 2'd3);
    step();
    instr_valid = 1'b0;
    instr = '0;
    check("s1_in0", ALUin0, 1);
    check("s1_oen", reg_out_en, 4'b0010);
    check("s1_ready", instr_ready, 0);
    check("s1_op", opControl, 3'b010);
    step();
    check("s2_in1", ALUin1, 1);
    check("s2_oen", reg_out_en, 4'b0100);
    step();
    check("s3_latch", ALUOutLatch, 1);
    check("s3_op", opControl, 3'b010);
    check("s3_oen", reg_out_en, 4'b0000);
    step();
    check("s4_outen", ALUOutEn, 1);
    check("s4_ien", reg_in_en, 4'b1000);
    step();
    check("s5_done", done, 1);
    check("s5_ready", instr_ready, 1);
    check("s5_busy", busy, 0);
    step();
    check("s6_done", done, 0);

    // back-to-back with valid held high; instr scrambled while busy
    bb[0] = mk(3'b001, 2'd0, 2'd3, 2'd1);
    bb[1] = mk(3'b111, 2'd3, 2'd3, 2'd0);
    bb[2] = mk(3'b100, 2'd2, 2'd1, 2'd2);
    dn0 = n_done;
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = bb[k];
      step();
      instr = ~bb[k];
      check("bb_op", opControl, bb[k][8:6]);
      check("bb_a", reg_out_en, onehot(bb[k][5:4]));
      step();
      check("bb_b", reg_out_en, onehot(bb[k][3:2]));
      step();
      check("bb_exec", ALUOutLatch, 1);
      step();
      check("bb_dst", reg_in_en, onehot(bb[k][1:0]));
      check("bb_op_w", opControl, bb[k][8:6]);
      step();
      check("bb_done", done, 1);
      check("bb_ready", instr_ready, 1);
    end
    instr_valid = 1'b0;
    step();
    check("bb_ndone", n_done - dn0, 3);

    // reset during EXEC
    dn0 = n_done;
    instr_valid = 1'b1;
    instr = mk(3'b011, 2'd0, 2'd1, 2'd2);
    step();
    instr_valid = 1'b0;
    step();
    step();
    check("rm_exec", ALUOutLatch, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rm_busy", busy, 0);
    check("rm_outen", ALUOutEn, 0);
    check("rm_strobes", {ALUin0, ALUin1, ALUOutLatch, reg_out_en, reg_in_en}, 0);
    check("rm_ready", instr_ready, 1);
    repeat (3) begin
      step();
      check("rm_outen2", ALUOutEn, 0);
    end
    check("rm_nodone", n_done - dn0, 0);

`ifdef SEQ_HOLD_EN
    instr_valid = 1'b1;
    instr = mk(3'b110, 2'd1, 2'd2, 2'd3);
    step();
    instr_valid = 1'b0;
    cyc = 1;
    step();
    cyc++;
    hold = 1'b1;
    check("h_strobes", {ALUin0, ALUin1, reg_out_en}, 0);
    check("h_busy", busy, 1);
    check("h_op", opControl, 3'b110);
    repeat (3) begin
      step();
      cyc++;
      check("h_frozen", {ALUin1, reg_out_en, ALUOutLatch}, 0);
    end
    hold = 1'b0;
    check("h_in1", ALUin1, 1);
    check("h_oen", reg_out_en, 4'b0100);
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
    check("h_latency", cyc, 8);
    step();
`endif

    // random traffic, then drain
    hs0 = n_hs;
    dn0 = n_done;
    for (int c = 0; c < 1000; c++) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr = 9'($urandom);
      step();
    end
    instr_valid = 1'b0;
    repeat (6) step();
    check("rnd_retire", n_done - dn0, n_hs - hs0);
    check("rnd_some", 32'((n_hs - hs0) > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
